// File: rtl/button_conditioner.sv
// Purpose : conditions raw asynchronous push-button pins into clean synchronous
//           level / press / release signals, one independent channel per pin.
// Latency : a raw step sampled first at edge k appears on level and its pulse at edge k+1+N.
// Backpressure: none; outputs are free-running registered signals.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-low reset
//   raw_in        raw pin levels, asynchronous to clock
//   level         debounced pressed state, active-high
//   press         1-clock pulse when level goes 0->1
//   release_pulse 1-clock pulse when level goes 1->0 ("release" is a reserved word)
module button_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   // Pin level of a released button; the synchronizer resets to it so that a
   // button held through reset is seen as a fresh press afterwards.
   localparam logic [CHANNELS-1:0] IDLE = {CHANNELS{ACTIVE_LOW}};

   logic [CHANNELS-1:0] s1;
   logic [CHANNELS-1:0] s2;
   logic [CHANNELS-1:0] p;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= IDLE;
         s2 <= IDLE;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // Polarity-corrected synced input: 1 = pressed.
   assign p = s2 ^ IDLE;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          lvl_q;
      logic          prs_q;
      logic          rel_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt   <= '0;
            lvl_q <= 1'b0;
            prs_q <= 1'b0;
            rel_q <= 1'b0;
         end else begin
            prs_q <= 1'b0;
            rel_q <= 1'b0;
            if (p[i] == lvl_q) begin
               // Any return to the accepted level restarts the stability count.
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               lvl_q <= p[i];
               cnt   <= '0;
               prs_q <= p[i];
               rel_q <= ~p[i];
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      assign level[i]         = lvl_q;
      assign press[i]         = prs_q;
      assign release_pulse[i] = rel_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] raw_in = 4'b0000;
   logic [3:0] raw2   = 4'b0000;
   logic [3:0] level, press, rel;
   logic [3:0] level2, press2, rel2;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // Active-low pins.
   button_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut (
      .clock(clock), .reset(reset), .raw_in(raw_in),
      .level(level), .press(press), .release_pulse(rel)
   );

   // Active-high pins.
   button_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1'b0)) dut2 (
      .clock(clock), .reset(reset), .raw_in(raw2),
      .level(level2), .press(press2), .release_pulse(rel2)
   );

   typedef struct {
      logic [3:0] raw;
      logic [3:0] raw2;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] lvl2;
      logic [3:0] prs2;
      logic [3:0] rel2;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [3:0] r, input logic [3:0] r2,
                      input logic [3:0] l, input logic [3:0] pr, input logic [3:0] re,
                      input logic [3:0] l2, input logic [3:0] pr2, input logic [3:0] re2,
                      input int n);
      vec_t v;
      v.raw = r;  v.raw2 = r2;
      v.lvl = l;  v.prs = pr;   v.rel = re;
      v.lvl2 = l2; v.prs2 = pr2; v.rel2 = re2;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag,
                            input logic [3:0] l, input logic [3:0] pr, input logic [3:0] re,
                            input logic [3:0] l2, input logic [3:0] pr2, input logic [3:0] re2);
      check({tag, " level"},    level,  l);
      check({tag, " press"},    press,  pr);
      check({tag, " release"},  rel,    re);
      check({tag, " level2"},   level2, l2);
      check({tag, " press2"},   press2, pr2);
      check({tag, " release2"}, rel2,   re2);
   endtask

   initial begin
      // Edge numbers in the comments count rising edges after reset deasserts.
      //     raw      raw2     lvl      prs      rel      lvl2     prs2     rel2     n
      // All active-low pins held pressed through reset: press at edge 10.
      add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 9); // 1..9
      add(4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1); // 10
      add(4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2); // 11..12
      // ch0 released (dut), ch3 pressed (dut2), first sampled at edge 13 -> edge 22.
      add(4'b0001, 4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 9); // 13..21
      add(4'b0001, 4'b1000, 4'b1110, 4'b0000, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 1); // 22
      add(4'b0001, 4'b1000, 4'b1110, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1); // 23
      // ch0 pressed again; dut2 ch0+ch1 pressed on the same edge -> edge 33.
      add(4'b0000, 4'b1011, 4'b1110, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 9); // 24..32
      add(4'b0000, 4'b1011, 4'b1111, 4'b0001, 4'b0000, 4'b1011, 4'b0011, 4'b0000, 1); // 33
      add(4'b0000, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1); // 34
      // ch1 deviation of exactly N-1 cycles: rejected.
      add(4'b0010, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 7); // 35..41
      add(4'b0000, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 5); // 42..46
      // ch1 bounce: 4 cycles away, 1 back, then held from edge 52 -> edge 61.
      add(4'b0010, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4); // 47..50
      add(4'b0000, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1); // 51
      add(4'b0010, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 9); // 52..60
      add(4'b0010, 4'b1011, 4'b1101, 4'b0000, 4'b0010, 4'b1011, 4'b0000, 4'b0000, 1); // 61
      add(4'b0010, 4'b1011, 4'b1101, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1); // 62
      // ch2 released (dut), ch3 released (dut2) from edge 63 -> edge 72.
      add(4'b0110, 4'b0011, 4'b1101, 4'b0000, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 9); // 63..71
      add(4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 4'b1000, 1); // 72
      add(4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1); // 73
      // ch1 and ch2 pressed together on dut -> simultaneous pulses at edge 83.
      add(4'b0000, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 9); // 74..82
      add(4'b0000, 4'b0011, 4'b1111, 4'b0110, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1); // 83
      add(4'b0000, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1); // 84

      // Reset state with clocks running.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b1;

      foreach (vecs[j]) begin
         raw_in = vecs[j].raw;
         raw2   = vecs[j].raw2;
         @(posedge clock);
         @(negedge clock);
         check_all($sformatf("edge%0d", j + 1), vecs[j].lvl, vecs[j].prs, vecs[j].rel,
                   vecs[j].lvl2, vecs[j].prs2, vecs[j].rel2);
      end

      // Reset in the middle of a ch0 release count (count reaches 5 after 7 edges).
      raw_in = 4'b0001;
      for (int e = 0; e < 7; e++) begin
         @(posedge clock);
         @(negedge clock);
         check_all($sformatf("midcount%0d", e), 4'b1111, 4'b0000, 4'b0000,
                   4'b0011, 4'b0000, 4'b0000);
      end
      reset  = 1'b0;
      raw_in = 4'b0000;
      #1;
      check_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_all("reset_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      reset = 1'b1;
      // Buttons held through reset need the full count again: press at edge 10.
      for (int e = 1; e <= 11; e++) begin
         @(posedge clock);
         @(negedge clock);
         if (e < 10)
            check_all($sformatf("after_reset%0d", e), 4'b0000, 4'b0000, 4'b0000,
                      4'b0000, 4'b0000, 4'b0000);
         else if (e == 10)
            check_all("after_reset10", 4'b1111, 4'b1111, 4'b0000, 4'b0011, 4'b0011, 4'b0000);
         else
            check_all("after_reset11", 4'b1111, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
